// File: rtl/clock_gen_pkg.sv
// +--------------------------------------------------------------+
// | clock_gen_pkg: FSM state type and default parameter values   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package clock_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_CHANNELS      = 2;
  localparam int DEF_ACC_W         = 24;
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES   = 2;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_enable_gen_if.sv
// +--------------------------------------------------------------+
// | clock_enable_gen_if: configuration write channel             |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

interface clock_enable_gen_if
  import clock_gen_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int ACC_W    = DEF_ACC_W
) ();

  localparam int CH_W = chan_w(CHANNELS);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_channel;
  logic [ACC_W-1:0] cfg_increment;

  modport master (
    output cfg_valid,
    output cfg_channel,
    output cfg_increment,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_channel,
    input  cfg_increment,
    output cfg_ready
  );

endinterface

`default_nettype wire

// File: rtl/clock_enable_gen_nco_channel.sv
// +--------------------------------------------------------------+
// | nco_channel: phase accumulator whose carry is the strobe     |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module nco_channel
  import clock_gen_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  wire logic             clock_in,
  input  wire logic             reset_n,
  input  wire logic             run_en,
  input  wire logic             load,
  input  wire logic [ACC_W-1:0] load_inc,
  output logic                  strobe
);

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // A write restarts the phase so the new rate begins from a clean origin.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      inc_q  <= '0;
      acc_q  <= '0;
      strobe <= 1'b0;
    end else if (load) begin
      inc_q  <= load_inc;
      acc_q  <= '0;
      strobe <= 1'b0;
    end else if (run_en) begin
      acc_q  <= sum[ACC_W-1:0];
      strobe <= sum[ACC_W];
    end else begin
      acc_q  <= '0;
      strobe <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_enable_gen.sv
// +--------------------------------------------------------------+
// | clock_enable_gen: lock-qualified multi-channel clock enables |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module clock_enable_gen
  import clock_gen_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  wire logic          clock_in,
  input  wire logic          reset_n,
  input  wire logic          locked_in,
  clock_enable_gen_if.slave  cfg,
  output logic               ready,
  output logic               reset_out_n,
  output logic [CHANNELS-1:0] strobe
);

  localparam int              CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state;
  logic [CNT_W-1:0]       settle_cnt;
  logic                   cfg_ready_q;
  logic                   cfg_accept;
  logic                   run_en;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // ready is registered alongside the state so it is high exactly in RUN.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_LOCK;
      settle_cnt  <= '0;
      ready       <= 1'b0;
      reset_out_n <= 1'b0;
    end else if (!locked_s) begin
      state       <= WAIT_LOCK;
      settle_cnt  <= '0;
      ready       <= 1'b0;
      reset_out_n <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state       <= RUN;
            ready       <= 1'b1;
            reset_out_n <= 1'b1;
          end
        end
        RUN: begin
          ready       <= 1'b1;
          reset_out_n <= 1'b1;
        end
        default: begin
          state       <= WAIT_LOCK;
          ready       <= 1'b0;
          reset_out_n <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cfg_ready_q <= 1'b0;
    end else begin
      cfg_ready_q <= 1'b1;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg_accept    = cfg.cfg_valid & cfg_ready_q;

  // Accumulate only while staying in RUN so strobes clear on the exit edge.
  assign run_en = (state == RUN) & locked_s;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic load;
      assign load = cfg_accept && (int'(cfg.cfg_channel) == i);

      nco_channel #(
        .ACC_W (ACC_W)
      ) u_nco (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .run_en   (run_en),
        .load     (load),
        .load_inc (cfg.cfg_increment),
        .strobe   (strobe[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_enable_gen.sv
// +--------------------------------------------------------------+
// | tb_clock_enable_gen: directed checks of lock FSM and NCOs    |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module tb_clock_enable_gen;

  localparam int CH = 3;
  localparam int AW = 8;
  localparam int SC = 4;
  localparam int SS = 2;

  logic          clock_in = 1'b0;
  logic          reset_n;
  logic          locked_in;
  logic          ready;
  logic          reset_out_n;
  logic [CH-1:0] strobe;

  int tests = 0;
  int fails = 0;

  clock_enable_gen_if #(.CHANNELS(CH), .ACC_W(AW)) cfg_bus ();

  clock_enable_gen #(
    .CHANNELS      (CH),
    .ACC_W         (AW),
    .SETTLE_CYCLES (SC),
    .SYNC_STAGES   (SS)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .locked_in   (locked_in),
    .cfg         (cfg_bus.slave),
    .ready       (ready),
    .reset_out_n (reset_out_n),
    .strobe      (strobe)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int inc);
    cfg_bus.cfg_valid     = 1'b1;
    cfg_bus.cfg_channel   = 2'(ch);
    cfg_bus.cfg_increment = 8'(inc);
    tick();
    cfg_bus.cfg_valid     = 1'b0;
  endtask

  task automatic run_count(input int n, output int c0, output int c1, output int c2, output int b2b);
    logic prev = 1'b0;
    c0 = 0; c1 = 0; c2 = 0; b2b = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      c0 += int'(strobe[0]);
      c1 += int'(strobe[1]);
      c2 += int'(strobe[2]);
      if (prev && strobe[0]) b2b++;
      prev = strobe[0];
    end
  endtask

  task automatic wait_ready(input logic lvl, input int max, input string tag);
    int n = 0;
    while (ready !== lvl && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(ready), 32'(lvl));
  endtask

  initial begin
    int c0, c1, c2, b2b, hits;

    reset_n               = 1'b0;
    locked_in             = 1'b1;
    cfg_bus.cfg_valid     = 1'b0;
    cfg_bus.cfg_channel   = '0;
    cfg_bus.cfg_increment = '0;

    repeat (3) tick();
    check("rst_ready",     32'(ready),             0);
    check("rst_reset_out", 32'(reset_out_n),       0);
    check("rst_strobe",    32'(strobe),            0);
    check("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 0);

    // Release with lock already high: ready must appear after edge 7 and not before.
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("ready_edge%0d", k), 32'(ready), (k == 7) ? 1 : 0);
      if (k == 1) check("cfg_ready_up", 32'(cfg_bus.cfg_ready), 1);
    end
    check("reset_out_eq_ready", 32'(reset_out_n), 1);

    cfg_write(1, 8'h00);
    cfg_write(0, 8'h40);
    check("strobe_after_write", 32'(strobe[0]), 0);
    run_count(64, c0, c1, c2, b2b);
    check("inc40_count", 32'(c0), 16);
    check("inc00_count", 32'(c1), 0);
    check("ch2_idle",    32'(c2), 0);

    // Accumulator is 0 again; the 4th edge from here would carry -> write on it.
    repeat (3) tick();
    cfg_write(0, 8'h40);
    check("write_on_overflow", 32'(strobe[0]), 0);
    run_count(3, c0, c1, c2, b2b);
    check("restart_quiet", 32'(c0), 0);
    tick();
    check("restart_first", 32'(strobe[0]), 1);

    cfg_write(3, 8'hFF);
    run_count(11, c0, c1, c2, b2b);
    check("oob_ch0",   32'(c0), 3);
    check("oob_other", 32'(c1 + c2), 0);

    cfg_write(0, 8'h55);
    run_count(768, c0, c1, c2, b2b);
    check("inc55_count", 32'(c0), 255);
    check("inc55_b2b",   32'(b2b), 0);

    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    wait_ready(1'b0, SS + 1, "lockdrop_ready_low");
    check("lockdrop_strobe",    32'(strobe), 0);
    check("lockdrop_reset_out", 32'(reset_out_n), 0);
    hits = 0;
    for (int k = 0; k < SC + 4 && ready !== 1'b1; k++) begin
      tick();
      if (ready !== 1'b1) hits += int'(strobe != '0);
    end
    check("relock_ready",        32'(ready), 1);
    check("relock_quiet_strobe", 32'(hits), 0);
    run_count(256, c0, c1, c2, b2b);
    check("relock_inc_kept", 32'(c0), 85);

    hits = 0;
    for (int k = 0; k < 8 && strobe[0] !== 1'b1; k++) tick();
    check("pre_reset_strobe", 32'(strobe[0]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_ready",     32'(ready),             0);
    check("async_reset_out", 32'(reset_out_n),       0);
    check("async_strobe",    32'(strobe),            0);
    check("async_cfg_ready", 32'(cfg_bus.cfg_ready), 0);
    tick();
    reset_n = 1'b1;
    wait_ready(1'b1, SS + SC + 4, "reset_relock_ready");
    run_count(64, c0, c1, c2, b2b);
    check("incs_cleared", 32'(c0 + c1 + c2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
